// File: rtl/spi_master_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl_pkg
// Shared definitions for the SPI master controller: FSM state encodings,
// SPI mode constants and the divider frequency-request helper.
// No ports.
// -----------------------------------------------------------------------------
package spi_master_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } spi_state_t;

   // Mode 0: sclk idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int FREQ_W = 32;

   // The divider produces one tick per half-period, so it is asked for twice
   // the sclk frequency.
   function automatic logic [FREQ_W-1:0] freq_request(input int unsigned spi_freq);
      return FREQ_W'(2 * spi_freq);
   endfunction

endpackage

// File: rtl/spi_master_ctrl_shift_reg.sv
// -----------------------------------------------------------------------------
// spi_shift_reg
// Transmit and receive shift registers for one SPI transfer, MSB first.
// The transmit MSB is driven onto mosi directly by the controller at start
// acceptance, so only the remaining DATA_W-1 bits are held here.
// Ports:
//   clk        system clock, posedge
//   rst_n      synchronous active-low reset
//   load       capture load_data into the tx register
//   load_data  tx bits below the MSB
//   shift_out  advance the tx register by one bit
//   tx_next    bit that goes out on mosi at the next falling sclk edge
//   shift_in   shift serial_in into the rx register LSB
//   serial_in  sampled miso bit
//   rx_data    received byte
// -----------------------------------------------------------------------------
module spi_shift_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-2:0] load_data,
   input  logic              shift_out,
   output logic              tx_next,
   input  logic              shift_in,
   input  logic              serial_in,
   output logic [DATA_W-1:0] rx_data
);

   logic [DATA_W-2:0] tx_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_q    <= '0;
         rx_data <= '0;
      end else begin
         if (load) begin
            tx_q <= load_data;
         end else if (shift_out) begin
            tx_q <= tx_q << 1;
         end
         if (shift_in) begin
            rx_data <= {rx_data[DATA_W-2:0], serial_in};
         end
      end
   end

   assign tx_next = tx_q[DATA_W-2];

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Sequences one SPI mode-0 transfer of DATA_W bits, MSB first, paced by the
// half-period tick of an external clock divider. The divider is parked
// (o_freq = 0) whenever no transfer is in flight so each transfer starts from
// a zeroed divider phase.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for i_start; cs_n high, divider parked
//   SETUP | cs_n low, first mosi bit valid; first tick raises sclk
//   XFER  | each tick toggles sclk; sample on rise, shift on fall
//   HOLD  | sclk low, cs_n low for CS_HOLD ticks after the last fall
//   DONE  | one cycle; o_done pulse, o_data valid
//
// Ports:
//   i_clk    system clock          i_rst_n  synchronous active-low reset
//   i_tick   divider half-period   o_freq   divider frequency request
//   i_start  start request         i_data   byte to send
//   o_busy   transfer in flight    o_done   one-cycle completion pulse
//   o_data   received byte         o_cs_n   chip select, active low
//   o_sclk   serial clock          o_mosi   serial data out
//   i_miso   serial data in (already synchronous to i_clk)
// -----------------------------------------------------------------------------
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 12000000,
   parameter int unsigned SPI_FREQ = 1000000,
   parameter int          DATA_W   = 8,
   parameter int          CS_HOLD  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tick,
   output logic [31:0]       o_freq,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_data,
   output logic              o_cs_n,
   output logic              o_sclk,
   output logic              o_mosi,
   input  logic              i_miso
);

   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD + 1) : 1;

   localparam logic [FREQ_W-1:0] FREQ_REQ  = freq_request(SPI_FREQ);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CS_HOLD);

   if (SPI_FREQ == 0) begin : g_bad_spi_freq
      $error("spi_master_ctrl: SPI_FREQ must be nonzero");
   end
   if ((2 * longint'(SPI_FREQ)) > longint'(CLK_FREQ)) begin : g_bad_ratio
      $error("spi_master_ctrl: 2*SPI_FREQ exceeds CLK_FREQ");
   end
   if (DATA_W < 2) begin : g_bad_width
      $error("spi_master_ctrl: DATA_W must be at least 2");
   end
   if (CS_HOLD < 0) begin : g_bad_hold
      $error("spi_master_ctrl: CS_HOLD must not be negative");
   end
   if (SPI_CPHA != 1'b0) begin : g_bad_mode
      $error("spi_master_ctrl: only CPHA=0 is sequenced here");
   end

   spi_state_t        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [HOLD_W-1:0] hold_cnt;

   logic              tx_load;
   logic              tx_shift;
   logic              rx_shift;
   logic              tx_next;
   logic [DATA_W-1:0] rx_q;

   // Shift enables mirror the FSM's tick decisions so the shift register
   // moves on exactly the same edges as sclk.
   always_comb begin
      tx_load  = (state == ST_IDLE) && i_start;
      rx_shift = i_tick && ((state == ST_SETUP) || ((state == ST_XFER) && !o_sclk));
      tx_shift = i_tick && (state == ST_XFER) && o_sclk;
   end

   spi_shift_reg #(
      .DATA_W (DATA_W)
   ) u_shift_reg (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .load      (tx_load),
      .load_data (i_data[DATA_W-2:0]),
      .shift_out (tx_shift),
      .tx_next   (tx_next),
      .shift_in  (rx_shift),
      .serial_in (i_miso),
      .rx_data   (rx_q)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         o_cs_n   <= 1'b1;
         o_sclk   <= SPI_CPOL;
         o_mosi   <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_data   <= '0;
         o_freq   <= '0;
         bit_cnt  <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A tick arriving together with the start is simply dropped.
               if (i_start) begin
                  state   <= ST_SETUP;
                  o_cs_n  <= 1'b0;
                  o_mosi  <= i_data[DATA_W-1];
                  o_freq  <= FREQ_REQ;
                  o_busy  <= 1'b1;
                  bit_cnt <= '0;
               end
            end

            ST_SETUP: begin
               if (i_tick) begin
                  state  <= ST_XFER;
                  o_sclk <= 1'b1;
               end
            end

            ST_XFER: begin
               if (i_tick) begin
                  if (!o_sclk) begin
                     o_sclk <= 1'b1;
                  end else begin
                     o_sclk  <= 1'b0;
                     o_mosi  <= tx_next;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == LAST_BIT) begin
                        if (CS_HOLD == 0) begin
                           state  <= ST_DONE;
                           o_cs_n <= 1'b1;
                           o_freq <= '0;
                           o_data <= rx_q;
                           o_done <= 1'b1;
                        end else begin
                           state    <= ST_HOLD;
                           hold_cnt <= HOLD_INIT;
                        end
                     end
                  end
               end
            end

            ST_HOLD: begin
               if (i_tick) begin
                  if (hold_cnt == HOLD_W'(1)) begin
                     state  <= ST_DONE;
                     o_cs_n <= 1'b1;
                     o_freq <= '0;
                     o_data <= rx_q;
                     o_done <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
            end

            ST_DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               o_mosi <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
